load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/load_extend.sv | 35 +++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------------+
// | lsu_pkg: shared FSM encoding, access-size codes, default timeout and the   |
// |          lane/alignment helpers for the load/store unit.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_DEFAULT_TIMEOUT = 255;

  // Reserved size codes are reported as misaligned so they never reach the bus.
  function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~a[0];
      F3_W:        ok = (a == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// +----------------------------------------------------------------------------+
// | load_extend: selects the addressed lane of a bus word and sign- or         |
// |              zero-extends it according to the access size code.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = raw >> {addr, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | load_store_unit: memory-stage LSU that turns pipeline load/store requests  |
// |                  into single bus transactions with alignment and timeout.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  logic [CW-1:0] busy_count;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic        request;
  logic        aligned;
  logic        accept;
  logic [31:0] load_value;

  assign request = MemReadM | MemWriteM;
  assign aligned = access_aligned(Funct3M, ALUResultM[1:0]);
  assign accept  = (state == IDLE) && request && aligned;

  // Held low during reset even if the pipeline keeps presenting an access.
  assign StallM = ~reset & (accept | (state == BUSY));

  load_extend u_load_extend (
    .raw    (mem_rdata),
    .addr   (addr_lo),
    .funct3 (funct3_q),
    .result (load_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy_count <= '0;
      addr_lo    <= '0;
      funct3_q   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      ReadDataM  <= '0;
      MisalignM  <= 1'b0;
      BusErrM    <= 1'b0;
    end else begin
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      ReadDataM <= '0;
      case (state)
        IDLE: begin
          if (request) begin
            if (aligned) begin
              // Write wins when both request lines are raised.
              mem_req    <= 1'b1;
              mem_we     <= MemWriteM;
              mem_addr   <= {ALUResultM[31:2], 2'b00};
              mem_be     <= lane_enable(Funct3M, ALUResultM[1:0]);
              mem_wdata  <= store_data(Funct3M, WriteDataM);
              addr_lo    <= ALUResultM[1:0];
              funct3_q   <= Funct3M;
              busy_count <= '0;
              state      <= BUSY;
            end else begin
              MisalignM <= 1'b1;
            end
          end
        end
        BUSY: begin
          // An ack on the final counted cycle still completes normally.
          if (mem_ack) begin
            mem_req    <= 1'b0;
            busy_count <= '0;
            state      <= DONE;
            if (!mem_we) ReadDataM <= load_value;
          end else if (busy_count == LAST_COUNT) begin
            mem_req    <= 1'b0;
            busy_count <= '0;
            BusErrM    <= 1'b1;
            state      <= DONE;
          end else begin
            busy_count <= busy_count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------------+
// | tb_load_store_unit: scoreboard bench for the load/store unit with a        |
// |                     behavioural model of sizes, lanes and timeout.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM)
  );

  typedef struct {
    bit          misalign;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          buserr;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_bytes(f3);
    return (n != 0) && ((a % n) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_bytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_bytes(f3))
      1:       return {24'b0, wd[7:0]} * 32'h01010101;
      2:       return {16'b0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [63:0] v;
    int bits;
    bits = 8 * size_bytes(f3);
    v = {32'b0, word} >> (8 * (a % 4));
    v = v & ((64'd1 << bits) - 64'd1);
    if ((f3 == 3'b000 || f3 == 3'b001) && v[bits-1]) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  // ack_at: BUSY cycle (1-based) in which mem_ack is raised; 0 means never.
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                            input logic wr, input logic [2:0] f3, input int ack_at,
                            input logic [31:0] rdat);
    exp_t e;
    bit acked;
    e.misalign = !model_legal(f3, a);
    e.we       = wr;
    e.addr     = {a[31:2], 2'b00};
    e.be       = model_be(f3, a);
    e.wdata    = model_wdata(f3, wd);
    acked      = (ack_at >= 1) && (ack_at <= T);
    e.buserr   = !acked;
    e.rdata    = (!wr && acked) ? model_load(f3, a, rdat) : 32'h0;
    e.stalls   = 1 + (acked ? ack_at : T);
    sb.push_back(e);

    // Stray acks while idle must be ignored.
    @(posedge clk); #1;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack    = 1'b0;
    ALUResultM = a;
    WriteDataM = wd;
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    @(posedge clk); #1;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    if (!e.misalign) begin
      for (int c = 1; c <= T; c++) begin
        mem_ack   = (c == ack_at);
        mem_rdata = (c == ack_at) ? rdat : $urandom;
        @(posedge clk); #1;
        if (c == ack_at) break;
      end
      mem_ack = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  bit          in_txn = 0;
  bit          unstable = 0;
  int          stall_seen = 0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn = 0;
        stall_seen = 0;
      end else begin
        if (StallM) stall_seen++;
        if (mem_req) begin
          if (!in_txn) begin
            in_txn = 1; unstable = 0;
            cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be;
          end else if (mem_we !== cap_we || mem_addr !== cap_addr ||
                       mem_wdata !== cap_wdata || mem_be !== cap_be) begin
            unstable = 1;
          end
        end else if (in_txn) begin
          in_txn = 0;
          if (sb.size() == 0) begin
            check("unexpected_transaction", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("kind_access", 32'(e.misalign), 32'd0);
            check("mem_addr", cap_addr, e.addr);
            check("mem_be", 32'(cap_be), 32'(e.be));
            check("mem_we", 32'(cap_we), 32'(e.we));
            if (e.we) check("mem_wdata", cap_wdata, e.wdata);
            check("bus_stable", 32'(unstable), 32'd0);
            check("ReadDataM", ReadDataM, e.rdata);
            check("BusErrM", 32'(BusErrM), 32'(e.buserr));
            check("stall_cycles", stall_seen, e.stalls);
            check("StallM_done", 32'(StallM), 32'd0);
          end
          stall_seen = 0;
        end
        if (MisalignM) begin
          if (sb.size() == 0) begin
            check("unexpected_misalign", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("kind_misalign", 32'(e.misalign), 32'd1);
            check("misalign_no_stall", stall_seen, 0);
            check("misalign_no_req", 32'(mem_req), 32'd0);
          end
          stall_seen = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [2:0] f3;
    logic rd, wr;
    reset = 1'b1;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #3;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_ReadDataM", ReadDataM, 0);
    check("rst_MisalignM", 32'(MisalignM), 0);
    check("rst_BusErrM", 32'(BusErrM), 0);
    check("rst_StallM", 32'(StallM), 0);
    MemReadM = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_access(32'h100, 32'h0, 1, 0, 3'b010, 3, 32'hDEADBEEF);
    run_access(32'h103, 32'h0, 1, 0, 3'b000, 1, 32'h80112233);
    run_access(32'h103, 32'h0, 1, 0, 3'b100, 2, 32'h80112233);
    run_access(32'h202, 32'h0000ABCD, 0, 1, 3'b001, 1, 32'h0);
    run_access(32'h101, 32'h0, 1, 0, 3'b010, 1, 32'h0);
    run_access(32'h200, 32'h0, 1, 0, 3'b011, 1, 32'h0);
    run_access(32'h300, 32'h0, 1, 0, 3'b010, 0, 32'h12345678);
    run_access(32'h302, 32'h0, 1, 0, 3'b001, T, 32'h8001F00D);
    run_access(32'h305, 32'h11223344, 1, 1, 3'b000, 2, 32'h0);

    // Reset in the middle of BUSY abandons the access.
    @(posedge clk); #1;
    ALUResultM = 32'h40; MemReadM = 1'b1; Funct3M = 3'b010;
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midbusy_mem_req", 32'(mem_req), 0);
    check("midbusy_StallM", 32'(StallM), 0);
    check("midbusy_BusErrM", 32'(BusErrM), 0);
    @(negedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < T + 2; i++) begin
      @(negedge clk);
      check("after_reset_BusErrM", 32'(BusErrM), 0);
    end

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      k  = $urandom_range(0, T + 2);
      run_access($urandom, $urandom, rd, wr, f3, k, $urandom);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
